// File: rtl/clk_div_pkg.sv
// Shared types and constants for the multi-channel clock divider.
// Optional build macro used by this slice: CLK_DIV_PHASE_ALIGN_EN.
package clk_div_pkg;

  // Counter / divisor width used by the channel configuration record.
  localparam int CNT_W = 32;

  // Post-reset channel setting: 100 Hz from a 100 MHz system clock.
  localparam logic [CNT_W-1:0] DEFAULT_DIV  = CNT_W'(1000000);
  localparam logic [CNT_W-1:0] DEFAULT_HIGH = CNT_W'(500000);

  // Smallest usable period; anything shorter cannot toggle.
  localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(2);

  // Per-channel configuration: period and high time, both in i_clk cycles.
  typedef struct packed {
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] high;
  } ch_cfg_t;

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: counter, active and shadow configuration, pending flag,
// registered divided clock and end-of-period tick.
// Optional build macro: CLK_DIV_PHASE_ALIGN_EN (i_sync restarts the period).
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter logic [CNT_W-1:0] RST_DIV  = DEFAULT_DIV,
  parameter logic [CNT_W-1:0] RST_HIGH = DEFAULT_HIGH
) (
  input  logic    i_clk,
  input  logic    i_rst,
  input  logic    i_en,
  input  logic    i_sync,
  input  logic    i_load,
  input  ch_cfg_t i_load_cfg,
  output logic    o_pending,
  output logic    o_clk,
  output logic    o_tick
);

  ch_cfg_t          act_p0;
  ch_cfg_t          shd_p0;
  logic [CNT_W-1:0] cnt_p0;
  logic             pend_p0;
  logic             clk_p1;
  logic             tick_p1;
  logic [CNT_W-1:0] div_eff;
  logic             wrap;
  logic             sync_hit;

  // Periods of 0 or 1 cycle are raised to the shortest period that can toggle.
  function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] d);
    return (d < MIN_DIV) ? MIN_DIV : d;
  endfunction

  assign div_eff = clamp_div(act_p0.div);
  assign wrap    = (cnt_p0 == (div_eff - CNT_W'(1)));

`ifdef CLK_DIV_PHASE_ALIGN_EN
  assign sync_hit = i_sync;
`else
  logic unused_sync;
  assign sync_hit    = 1'b0;
  assign unused_sync = i_sync;
`endif

  // Counter, configuration swap at period boundary, and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_p0  <= '0;
      act_p0  <= '{div: RST_DIV, high: RST_HIGH};
      shd_p0  <= '0;
      pend_p0 <= 1'b0;
      clk_p1  <= 1'b0;
      tick_p1 <= 1'b0;
    end else begin
      // A load is only offered while nothing is pending, so it never
      // collides with the apply paths below (those need pend_p0 = 1).
      if (i_load) begin
        shd_p0  <= i_load_cfg;
        pend_p0 <= 1'b1;
      end
      if (!i_en) begin
        cnt_p0  <= '0;
        clk_p1  <= 1'b0;
        tick_p1 <= 1'b0;
        if (pend_p0) begin
          act_p0  <= shd_p0;
          pend_p0 <= 1'b0;
        end
      end else if (sync_hit) begin
        cnt_p0  <= '0;
        tick_p1 <= 1'b0;
        clk_p1  <= (act_p0.high != '0);
        if (pend_p0) begin
          act_p0  <= shd_p0;
          pend_p0 <= 1'b0;
        end
      end else begin
        cnt_p0  <= wrap ? '0 : cnt_p0 + CNT_W'(1);
        tick_p1 <= wrap;
        clk_p1  <= (cnt_p0 < act_p0.high);
        if (wrap && pend_p0) begin
          act_p0  <= shd_p0;
          pend_p0 <= 1'b0;
        end
      end
    end
  end

  assign o_pending = pend_p0;
  assign o_clk     = clk_p1;
  assign o_tick    = tick_p1;

endmodule

// File: rtl/clk_divider_multi.sv
// N-channel clock divider / tick generator with shadowed, glitch-free
// divisor and duty updates through a valid/ready load port.
// Optional build macro: CLK_DIV_PHASE_ALIGN_EN (i_sync phase-aligns channels;
// without it i_sync is ignored).
// CNT_W must equal the package counter width, which sizes the config record.
module clk_divider_multi #(
  parameter int N_CH  = 4,
  parameter int CNT_W = clk_div_pkg::CNT_W,
  parameter int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1,
  parameter logic [clk_div_pkg::CNT_W-1:0] DEFAULT_DIV  = clk_div_pkg::DEFAULT_DIV,
  parameter logic [clk_div_pkg::CNT_W-1:0] DEFAULT_HIGH = clk_div_pkg::DEFAULT_HIGH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_CH-1:0]  i_en,
  input  logic             i_load_valid,
  output logic             o_load_ready,
  input  logic [CH_W-1:0]  i_load_ch,
  input  logic [CNT_W-1:0] i_load_div,
  input  logic [CNT_W-1:0] i_load_high,
  input  logic             i_sync,
  output logic [N_CH-1:0]  o_clk,
  output logic [N_CH-1:0]  o_tick
);

  import clk_div_pkg::*;

  logic [N_CH-1:0] pending;
  logic [N_CH-1:0] load_hit;
  logic            ready;
  ch_cfg_t         load_cfg;

  assign load_cfg = '{div: i_load_div, high: i_load_high};

  // Ready follows the selected channel's pending flag; out-of-range
  // channel numbers are always ready and their requests go nowhere.
  always_comb begin
    ready = 1'b1;
    for (int i = 0; i < N_CH; i++) begin
      if (i_load_ch == CH_W'(i)) ready = !pending[i];
    end
  end

  assign o_load_ready = ready;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    assign load_hit[g] = i_load_valid && ready && (i_load_ch == CH_W'(g));

    clk_div_channel #(
      .RST_DIV  (DEFAULT_DIV),
      .RST_HIGH (DEFAULT_HIGH)
    ) u_ch (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_en       (i_en[g]),
      .i_sync     (i_sync),
      .i_load     (load_hit[g]),
      .i_load_cfg (load_cfg),
      .o_pending  (pending[g]),
      .o_clk      (o_clk[g]),
      .o_tick     (o_tick[g])
    );
  end

endmodule
